// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared types and constants for the SM83 datapath
package sm83_pkg;

  typedef enum logic [1:0] {
    ADDR_PC   = 2'd0,
    ADDR_GP16 = 2'd1,
    ADDR_WZ   = 2'd2
  } addr_sel_t;

  typedef enum logic [2:0] {
    R8_B     = 3'd0,
    R8_C     = 3'd1,
    R8_D     = 3'd2,
    R8_E     = 3'd3,
    R8_H     = 3'd4,
    R8_L     = 3'd5,
    R8_HLPTR = 3'd6,
    R8_A     = 3'd7
  } r8_sel_t;

  // SP is reserved and routes the bus to PC until a stack pointer exists.
  typedef enum logic [1:0] {
    R16_BC = 2'd0,
    R16_DE = 2'd1,
    R16_HL = 2'd2,
    R16_SP = 2'd3
  } r16_sel_t;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

endpackage

// File: rtl/sm83_regfile.sv
// rtl/sm83_regfile.sv - SM83 8-bit register file (B,C,D,E,H,L,A) plus F
module sm83_regfile
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  r8_sel_t     i_wsel,
  input  logic [7:0]  i_wdata,
  input  logic        i_flags_we,
  input  logic [3:0]  i_flags,
  input  r8_sel_t     i_src_sel,
  input  r16_sel_t    i_r16_sel,
  output logic [7:0]  o_src_data,
  output logic [7:0]  o_a_data,
  output logic [15:0] o_pair_data,
  output logic [3:0]  o_flags
);

  // Slot 6 (HLPTR) is never written, so it always reads back as zero.
  logic [7:0] r_regs [0:7];
  logic [3:0] r_f;
  logic [7:0] w_f_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
      r_f <= 4'h0;
    end else begin
      if (i_we && (i_wsel != R8_HLPTR)) r_regs[i_wsel] <= i_wdata;
      if (i_flags_we) r_f <= i_flags;
    end
  end

  assign w_f_full   = {r_f, 4'h0};
  assign o_flags    = w_f_full[FLAG_Z:FLAG_C];
  assign o_src_data = r_regs[i_src_sel];
  assign o_a_data   = r_regs[R8_A];

  always_comb begin
    o_pair_data = 16'h0000;
    case (i_r16_sel)
      R16_BC:  o_pair_data = {r_regs[R8_B], r_regs[R8_C]};
      R16_DE:  o_pair_data = {r_regs[R8_D], r_regs[R8_E]};
      R16_HL:  o_pair_data = {r_regs[R8_H], r_regs[R8_L]};
      default: o_pair_data = 16'h0000;
    endcase
  end

endmodule

// File: rtl/sm83_datapath.sv
// rtl/sm83_datapath.sv - SM83 architectural state and bus address/ALU operand muxing
module sm83_datapath
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  RESET_IR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  addr_sel_t   i_addr_sel,
  input  logic        i_inc_pc,
  input  logic        i_mem_to_ir,
  input  logic        i_mem_to_z,
  input  logic        i_mem_to_w,
  input  logic        i_mem_to_r8,
  input  logic        i_capture_alu_res,
  input  logic        i_r8_to_alu_op1,
  input  logic        i_update_flags,
  input  logic        i_r8_to_mem,
  input  logic        i_z_to_mem,
  input  logic        i_halt,
  input  r8_sel_t     i_dst_sel,
  input  r8_sel_t     i_src_sel,
  input  r16_sel_t    i_r16_sel,
  input  logic [7:0]  i_mem_rdata,
  input  logic [7:0]  i_alu_res,
  input  logic [3:0]  i_alu_flags,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_we,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [3:0]  o_flags,
  output logic [7:0]  o_ir,
  output logic [15:0] o_pc
);

  logic [15:0] r_pc;
  logic [7:0]  r_ir;
  logic [7:0]  r_z;
  logic [7:0]  r_w;
  logic        w_r8_we;
  logic [7:0]  w_r8_wdata;
  logic [7:0]  w_src_data;
  logic [7:0]  w_a_data;
  logic [15:0] w_pair_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_ir <= RESET_IR;
      r_z  <= 8'h00;
      r_w  <= 8'h00;
    end else begin
      if (i_inc_pc && !i_halt)    r_pc <= r_pc + 16'd1;
      if (i_mem_to_ir && !i_halt) r_ir <= i_mem_rdata;
      if (i_mem_to_z)             r_z  <= i_mem_rdata;
      if (i_mem_to_w)             r_w  <= i_mem_rdata;
    end
  end

  // ALU result beats memory data when both target the register file.
  assign w_r8_we    = i_capture_alu_res | i_mem_to_r8;
  assign w_r8_wdata = i_capture_alu_res ? i_alu_res : i_mem_rdata;

  sm83_regfile u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_r8_we),
    .i_wsel      (i_dst_sel),
    .i_wdata     (w_r8_wdata),
    .i_flags_we  (i_update_flags),
    .i_flags     (i_alu_flags),
    .i_src_sel   (i_src_sel),
    .i_r16_sel   (i_r16_sel),
    .o_src_data  (w_src_data),
    .o_a_data    (w_a_data),
    .o_pair_data (w_pair_data),
    .o_flags     (o_flags)
  );

  always_comb begin
    o_mem_addr = r_pc;
    case (i_addr_sel)
      ADDR_PC:   o_mem_addr = r_pc;
      ADDR_GP16: o_mem_addr = (i_r16_sel == R16_SP) ? r_pc : w_pair_data;
      ADDR_WZ:   o_mem_addr = {r_w, r_z};
      default:   o_mem_addr = r_pc;
    endcase
  end

  assign o_mem_we    = rst_n & (i_r8_to_mem | i_z_to_mem);
  assign o_mem_wdata = i_r8_to_mem ? w_src_data : r_z;
  assign o_alu_a     = (i_r8_to_alu_op1 && (i_src_sel != R8_HLPTR)) ? w_src_data : r_z;
  assign o_alu_b     = w_a_data;
  assign o_ir        = r_ir;
  assign o_pc        = r_pc;

endmodule

// File: tb/tb_sm83_datapath.sv
// tb/tb_sm83_datapath.sv - self-checking bench for sm83_datapath
module tb_sm83_datapath;
  import sm83_pkg::*;

  localparam logic [10:0] S_INC  = 11'h001;
  localparam logic [10:0] S_MIR  = 11'h002;
  localparam logic [10:0] S_MZ   = 11'h004;
  localparam logic [10:0] S_MW   = 11'h008;
  localparam logic [10:0] S_MR8  = 11'h010;
  localparam logic [10:0] S_CAP  = 11'h020;
  localparam logic [10:0] S_OP1  = 11'h040;
  localparam logic [10:0] S_UF   = 11'h080;
  localparam logic [10:0] S_R8M  = 11'h100;
  localparam logic [10:0] S_ZM   = 11'h200;
  localparam logic [10:0] S_HALT = 11'h400;

  typedef struct {
    logic [10:0] stb;
    logic [1:0]  as;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [1:0]  r16;
    logic [7:0]  rd;
    logic [7:0]  ar;
    logic [3:0]  af;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_we;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic [3:0]  e_f;
    logic [7:0]  e_ir;
    logic [15:0] e_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  addr_sel_t addr_sel;
  logic inc_pc, mem_to_ir, mem_to_z, mem_to_w, mem_to_r8, capture_alu_res;
  logic r8_to_alu_op1, update_flags, r8_to_mem, z_to_mem, halt;
  r8_sel_t dst_sel, src_sel;
  r16_sel_t r16_sel;
  logic [7:0] mem_rdata, alu_res;
  logic [3:0] alu_flags;
  logic [15:0] mem_addr, pc;
  logic [7:0] mem_wdata, alu_a, alu_b, ir;
  logic mem_we;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [7:0]  m_ir, m_z, m_w, m_f_unused;
  logic [7:0]  m_r [0:7];
  logic [3:0]  m_f;

  vec_t vecs [0:19];

  always #5 clk = ~clk;

  sm83_datapath dut (
    .clk(clk), .rst_n(rst_n), .i_addr_sel(addr_sel), .i_inc_pc(inc_pc),
    .i_mem_to_ir(mem_to_ir), .i_mem_to_z(mem_to_z), .i_mem_to_w(mem_to_w),
    .i_mem_to_r8(mem_to_r8), .i_capture_alu_res(capture_alu_res),
    .i_r8_to_alu_op1(r8_to_alu_op1), .i_update_flags(update_flags),
    .i_r8_to_mem(r8_to_mem), .i_z_to_mem(z_to_mem), .i_halt(halt),
    .i_dst_sel(dst_sel), .i_src_sel(src_sel), .i_r16_sel(r16_sel),
    .i_mem_rdata(mem_rdata), .i_alu_res(alu_res), .i_alu_flags(alu_flags),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_flags(flags), .o_ir(ir), .o_pc(pc)
  );

  always @(negedge clk) begin
    if (rst_n) assert (!(r8_to_mem && z_to_mem))
      else $error("FAIL illegal_strobes: r8_to_mem=%b z_to_mem=%b required not both", r8_to_mem, z_to_mem);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    inc_pc          = v.stb[0];
    mem_to_ir       = v.stb[1];
    mem_to_z        = v.stb[2];
    mem_to_w        = v.stb[3];
    mem_to_r8       = v.stb[4];
    capture_alu_res = v.stb[5];
    r8_to_alu_op1   = v.stb[6];
    update_flags    = v.stb[7];
    r8_to_mem       = v.stb[8];
    z_to_mem        = v.stb[9];
    halt            = v.stb[10];
    addr_sel  = addr_sel_t'(v.as);
    dst_sel   = r8_sel_t'(v.dst);
    src_sel   = r8_sel_t'(v.src);
    r16_sel   = r16_sel_t'(v.r16);
    mem_rdata = v.rd;
    alu_res   = v.ar;
    alu_flags = v.af;
  endtask

  function automatic vec_t mk(input logic [10:0] stb, input logic [1:0] as,
                              input logic [2:0] dst, input logic [2:0] src,
                              input logic [1:0] r16, input logic [7:0] rd,
                              input logic [7:0] ar, input logic [3:0] af);
    vec_t v;
    v = '{stb, as, dst, src, r16, rd, ar, af, 16'h0, 8'h0, 1'b0, 8'h0, 8'h0, 4'h0, 8'h0, 16'h0};
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = 8'h00; m_z = 8'h00; m_w = 8'h00; m_f = 4'h0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
  endtask

  // Architectural effect of one clock edge under the currently driven strobes.
  task automatic model_edge();
    int d;
    d = int'(dst_sel);
    if (inc_pc && !halt) m_pc = 16'((32'(m_pc) + 1) % 65536);
    if (mem_to_ir && !halt) m_ir = mem_rdata;
    if (mem_to_z) m_z = mem_rdata;
    if (mem_to_w) m_w = mem_rdata;
    if (d != 6) begin
      if (capture_alu_res) m_r[d] = alu_res;
      else if (mem_to_r8)  m_r[d] = mem_rdata;
    end
    if (update_flags) m_f = alu_flags;
  endtask

  task automatic check_model();
    logic [15:0] e_addr;
    int s;
    s = int'(src_sel);
    e_addr = m_pc;
    if (addr_sel == ADDR_WZ) e_addr = {m_w, m_z};
    else if (addr_sel == ADDR_GP16) begin
      case (int'(r16_sel))
        0: e_addr = {m_r[0], m_r[1]};
        1: e_addr = {m_r[2], m_r[3]};
        2: e_addr = {m_r[4], m_r[5]};
        default: e_addr = m_pc;
      endcase
    end
    chk("rnd_addr", mem_addr, e_addr);
    chk("rnd_we", 16'(mem_we), 16'(r8_to_mem | z_to_mem));
    if (r8_to_mem) chk("rnd_wdata", 16'(mem_wdata), 16'(m_r[s]));
    else           chk("rnd_wdata", 16'(mem_wdata), 16'(m_z));
    chk("rnd_alu_a", 16'(alu_a), 16'((r8_to_alu_op1 && s != 6) ? m_r[s] : m_z));
    chk("rnd_alu_b", 16'(alu_b), 16'(m_r[7]));
    chk("rnd_flags", 16'(flags), 16'(m_f));
    chk("rnd_ir", 16'(ir), 16'(m_ir));
    chk("rnd_pc", pc, m_pc);
  endtask

  task automatic step_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    vec_t v;
    int n;
    m_f_unused = 8'h00;

    //        stb                     as    dst   src   r16   rd     ar     af    | addr    wd    we   a      b      f     ir     pc
    vecs[0]  = '{11'h0,              2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[1]  = '{S_MZ,               2'd0, 3'd0, 3'd0, 2'd0, 8'h34, 8'h00, 4'h0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[2]  = '{S_MW,               2'd0, 3'd0, 3'd0, 2'd0, 8'h12, 8'h00, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[3]  = '{11'h0,              2'd2, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0, 16'h1234, 8'h34, 1'b0, 8'h34, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[4]  = '{S_CAP,              2'd0, 3'd4, 3'd0, 2'd0, 8'h00, 8'hC0, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[5]  = '{S_CAP,              2'd0, 3'd5, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[6]  = '{S_CAP,              2'd0, 3'd7, 3'd0, 2'd0, 8'h00, 8'h5A, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h00, 4'h0, 8'h00, 16'h0000};
    vecs[7]  = '{S_R8M,              2'd1, 3'd0, 3'd7, 2'd2, 8'h00, 8'h00, 4'h0, 16'hC000, 8'h5A, 1'b1, 8'h34, 8'h5A, 4'h0, 8'h00, 16'h0000};
    vecs[8]  = '{S_CAP|S_MR8|S_UF,   2'd0, 3'd0, 3'd0, 2'd0, 8'h11, 8'h77, 4'hA, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h5A, 4'h0, 8'h00, 16'h0000};
    vecs[9]  = '{S_OP1,              2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h77, 8'h5A, 4'hA, 8'h00, 16'h0000};
    vecs[10] = '{S_CAP|S_OP1,        2'd0, 3'd6, 3'd6, 2'd0, 8'h00, 8'hEE, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h5A, 4'hA, 8'h00, 16'h0000};
    vecs[11] = '{S_OP1|S_R8M,        2'd0, 3'd0, 3'd4, 2'd0, 8'h00, 8'h00, 4'h0, 16'h0000, 8'hC0, 1'b1, 8'hC0, 8'h5A, 4'hA, 8'h00, 16'h0000};
    vecs[12] = '{S_INC|S_MIR,        2'd0, 3'd0, 3'd0, 2'd0, 8'h3C, 8'h00, 4'h0, 16'h0000, 8'h34, 1'b0, 8'h34, 8'h5A, 4'hA, 8'h00, 16'h0000};
    vecs[13] = '{S_INC|S_MIR|S_MZ|S_HALT, 2'd0, 3'd0, 3'd0, 2'd0, 8'h99, 8'h00, 4'h0, 16'h0001, 8'h34, 1'b0, 8'h34, 8'h5A, 4'hA, 8'h3C, 16'h0001};
    vecs[14] = '{S_OP1,              2'd1, 3'd0, 3'd5, 2'd0, 8'h00, 8'h00, 4'h0, 16'h7700, 8'h99, 1'b0, 8'h00, 8'h5A, 4'hA, 8'h3C, 16'h0001};
    vecs[15] = '{11'h0,              2'd3, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0, 16'h0001, 8'h99, 1'b0, 8'h99, 8'h5A, 4'hA, 8'h3C, 16'h0001};
    vecs[16] = '{11'h0,              2'd1, 3'd0, 3'd0, 2'd3, 8'h00, 8'h00, 4'h0, 16'h0001, 8'h99, 1'b0, 8'h99, 8'h5A, 4'hA, 8'h3C, 16'h0001};
    vecs[17] = '{S_CAP,              2'd0, 3'd2, 3'd0, 2'd0, 8'h00, 8'hAB, 4'h0, 16'h0001, 8'h99, 1'b0, 8'h99, 8'h5A, 4'hA, 8'h3C, 16'h0001};
    vecs[18] = '{S_CAP,              2'd0, 3'd3, 3'd0, 2'd0, 8'h00, 8'hCD, 4'h0, 16'h0001, 8'h99, 1'b0, 8'h99, 8'h5A, 4'hA, 8'h3C, 16'h0001};
    vecs[19] = '{11'h0,              2'd1, 3'd0, 3'd0, 2'd1, 8'h00, 8'h00, 4'h0, 16'hABCD, 8'h99, 1'b0, 8'h99, 8'h5A, 4'hA, 8'h3C, 16'h0001};

    apply(mk(11'h0, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 16'h0000);
    chk("reset_ir", 16'(ir), 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), 16'(mem_wdata), 16'(vecs[i].e_wd));
      chk($sformatf("v%0d_we", i), 16'(mem_we), 16'(vecs[i].e_we));
      chk($sformatf("v%0d_alu_a", i), 16'(alu_a), 16'(vecs[i].e_a));
      chk($sformatf("v%0d_alu_b", i), 16'(alu_b), 16'(vecs[i].e_b));
      chk($sformatf("v%0d_flags", i), 16'(flags), 16'(vecs[i].e_f));
      chk($sformatf("v%0d_ir", i), 16'(ir), 16'(vecs[i].e_ir));
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      step_edge();
    end

    // Walk PC up to 0xFFFF, then probe halt and the wrap.
    apply(mk(S_INC, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    n = 0;
    while (m_pc != 16'hFFFF && n < 70000) begin
      @(posedge clk);
      model_edge();
      n++;
    end
    #1;
    apply(mk(11'h0, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    @(negedge clk);
    chk("walk_pc_ffff", pc, 16'hFFFF);
    apply(mk(S_INC|S_MIR|S_HALT, 2'd0, 3'd0, 3'd0, 2'd0, 8'h55, 8'h00, 4'h0));
    step_edge();
    apply(mk(11'h0, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    @(negedge clk);
    chk("halt_pc_hold", pc, 16'hFFFF);
    chk("halt_ir_hold", 16'(ir), 16'h003C);
    apply(mk(S_INC, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    step_edge();
    apply(mk(11'h0, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    @(negedge clk);
    chk("pc_wrap", pc, 16'h0000);
    @(posedge clk);
    #1;

    for (int k = 0; k < 1500; k++) begin
      logic [10:0] stb;
      logic [2:0] src;
      int wsel;
      stb = 11'($urandom) & ~(S_R8M | S_ZM | S_HALT);
      if ($urandom_range(0, 7) == 0) stb = stb | S_HALT;
      wsel = $urandom_range(0, 3);
      src = 3'($urandom);
      if (wsel == 1) begin
        stb = stb | S_R8M;
        if (src == 3'd6) src = 3'd7;
      end else if (wsel == 2) begin
        stb = stb | S_ZM;
      end
      v = mk(stb, 2'($urandom), 3'($urandom), src, 2'($urandom),
             8'($urandom), 8'($urandom), 4'($urandom));
      apply(v);
      @(negedge clk);
      check_model();
      step_edge();
    end

    // Asynchronous reset in the middle of a cycle.
    apply(mk(S_CAP, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h77, 4'h0));
    step_edge();
    apply(mk(S_INC|S_OP1|S_R8M, 2'd0, 3'd0, 3'd0, 2'd0, 8'h00, 8'h00, 4'h0));
    #1;
    chk("pre_rst_b", 16'(alu_a), 16'h0077);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_b", 16'(alu_a), 16'h0000);
    chk("async_rst_pc", pc, 16'h0000);
    chk("async_rst_we", 16'(mem_we), 16'h0000);
    chk("async_rst_flags", 16'(flags), 16'h0000);
    chk("async_rst_ir", 16'(ir), 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step_edge();
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm83_datapath.md
Name: sm83_datapath

Overview:
- Architectural state holder and bus-address generator directly downstream of the SM83 execute-sequence controller.
- Consumes the controller's per-cycle strobes (addr_sel, inc_pc, mem_to_*, capture_alu_res, r8_to_alu_op1, update_flags, r8_to_mem, z_to_mem, halt) plus decoder register selects.
- Owns PC, IR, Z/W temporaries, the 8-bit register file (B,C,D,E,H,L,A) and F.
- Drives the memory address/write interface and the ALU operand/result path.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RESET_IR, 8'h00, IR value on reset (NOP, so the first fetch executes cleanly)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
addr_sel  in  addr_sel_t  bus address source: PC, GP16 or WZ
inc_pc  in  1  PC <= PC+1 this edge
mem_to_ir  in  1  IR <= mem_rdata
mem_to_z  in  1  Z <= mem_rdata
mem_to_w  in  1  W <= mem_rdata
mem_to_r8  in  1  r8[dst_sel] <= mem_rdata
capture_alu_res  in  1  r8[dst_sel] <= alu_res
r8_to_alu_op1  in  1  ALU operand A sourced from r8[src_sel] instead of Z
update_flags  in  1  F[7:4] <= alu_flags
r8_to_mem  in  1  write r8[src_sel] to memory
z_to_mem  in  1  write Z to memory
halt  in  1  core halted; freezes PC and IR
dst_sel  in  r8_sel_t  destination register index
src_sel  in  r8_sel_t  source register index
r16_sel  in  r16_sel_t  pair used when addr_sel==GP16
mem_rdata  in  8  memory read data
alu_res  in  8  ALU result
alu_flags  in  4  ZNHC from ALU
mem_addr  out  16  bus address
mem_wdata  out  8  bus write data
mem_we  out  1  bus write strobe
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B (always A register)
flags  out  4  current F[7:4] to ALU/branch logic
ir  out  8  instruction register to decoder
pc  out  16  program counter (debug/trace)

Behaviour:
- Reset (async, rst_n low): PC=RESET_PC; IR=RESET_IR; Z=W=0; B,C,D,E,H,L,A=0; F=0. Outputs derived combinationally from this state. mem_we=0 during reset.
- mem_addr is combinational, zero latency:
  - PC -> PC.
  - WZ -> {W,Z}.
  - GP16 -> {B,C}, {D,E} or {H,L} per r16_sel.
  - Any other encoding -> PC.
- mem_we = r8_to_mem | z_to_mem.
- mem_wdata = r8_to_mem ? r8[src_sel] : Z. Both strobes asserted: r8 wins. Illegal combination; the bench flags it with an assertion.
- alu_a = (r8_to_alu_op1 && src_sel!=HLPTR) ? r8[src_sel] : Z.
- alu_b = A.
- All register updates occur on the rising clk edge.
- Same-cycle reads return pre-edge values; there is no write-through bypass.
- PC: inc_pc && !halt -> PC+1, modulo 2^16 (0xFFFF wraps to 0x0000).
- IR: mem_to_ir && !halt -> mem_rdata.
- halt blocks only PC and IR. Z, W, r8 and F writes still complete on the halting cycle.
- r8 writes:
  - capture_alu_res has priority over mem_to_r8 when both are set.
  - dst_sel==HLPTR (index 6) discards the write; memory writes go through the bus.
  - Index 7 = A.
- F:
  - update_flags writes F[7:4]=alu_flags. F[3:0] read as 0 always; they are not stored.
  - A flags update and an r8 write in the same cycle both take effect.
- Z, W, IR and r8 may all load from mem_rdata in one cycle; each honours its own strobe independently.
- Reset asserted mid-sequence: all state returns to reset values immediately. No partial write completes.

Decomposition:
- sm83_pkg already holds addr_sel_t.
- Add to sm83_pkg:
  - r8_sel_t: B=0, C, D, E, H, L, HLPTR=6, A=7.
  - r16_sel_t: BC=0, DE, HL, SP=3. SP is reserved; it maps to the PC address source until SP is implemented.
  - F flag bit-position constants: FLAG_Z=7, FLAG_N=6, FLAG_H=5, FLAG_C=4.
- One sub-module, sm83_regfile:
  - Contents: the seven 8-bit registers and F.
  - Ports: 1 write port, 2 read ports (src and A), pair read for r16_sel.
- PC/IR/Z/W and the muxes stay in sm83_datapath.

Test Plan:
- Reset then release, no strobes -> pc=0x0000, ir=0x00, mem_addr=0x0000, mem_we=0, all regs 0.
- PC at 0xFFFF, inc_pc=1 for one cycle -> pc=0x0000. Same with halt=1 -> pc stays 0xFFFF and ir unchanged despite mem_to_ir=1.
- mem_rdata=0x34 with mem_to_z, next cycle 0x12 with mem_to_w, then addr_sel=WZ -> mem_addr=0x1234. mem_to_z with mem_rdata=0xAB -> Z=0xAB.
- dst_sel=H with alu_res=0xC0, then dst_sel=L with alu_res=0x00, then addr_sel=GP16, r16_sel=HL, r8_to_mem=1, src_sel=A (A=0x5A) -> mem_addr=0xC000, mem_we=1, mem_wdata=0x5A.
- Same cycle: capture_alu_res=1 with alu_res=0x77, mem_to_r8=1 with mem_rdata=0x11, dst_sel=B, update_flags with alu_flags=4'b1010 -> B=0x77, flags=4'b1010.
- Write to dst_sel=HLPTR -> no register changes. Assert rst_n low mid-sequence with B=0x77 -> B=0x00 and pc=RESET_PC without waiting for a clock edge.
